// File: rtl/core_pkg.sv
// ---------------------------------------------------------------------------
// core_pkg
// Shared types and constants for the memory-port arbiter.
//   arb_state_t : arbiter FSM state encoding
//   MODE_*      : access-size encoding carried on dc_mode / mem_mode
// ---------------------------------------------------------------------------
package core_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_IF_BUSY = 2'b01,
      ST_DC_BUSY = 2'b10
   } arb_state_t;

   localparam logic [1:0] MODE_BYTE = 2'b00;
   localparam logic [1:0] MODE_HALF = 2'b01;
   localparam logic [1:0] MODE_WORD = 2'b10;

endpackage

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-outstanding memory port between an instruction-fetch
// requester (if_*) and a data requester (dc_*). Data has priority, but the
// fetch side is granted after STARVE_MAX consecutive data grants that were
// made while fetch was waiting. A transaction that sees no mem_ack within
// TIMEOUT wait cycles is aborted and reported on err.
//
// Ports
//   clk, rstn                 clock, asynchronous active-low reset
//   if_req, if_addr           fetch read request and address
//   if_gnt                    fetch request accepted (combinational pulse)
//   if_rvalid, if_rdata       fetch read data return (one-cycle pulse)
//   dc_req, dc_rw, dc_addr,
//   dc_wdata, dc_mode         data request (rw: 1=write), payload, size
//   dc_gnt                    data request accepted (combinational pulse)
//   dc_rvalid, dc_rdata       data access complete (read data, 0 on write)
//   mem_req, mem_rw, mem_addr,
//   mem_wdata, mem_mode       registered memory-side request
//   mem_ack, mem_rdata        memory completion and read data
//   err                       timeout abort (one-cycle pulse)
// ---------------------------------------------------------------------------
module mem_port_arbiter
   import core_pkg::*;
#(
   parameter int STARVE_MAX = 4,
   parameter int TIMEOUT    = 255
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_gnt,
   output logic        if_rvalid,
   output logic [31:0] if_rdata,
   input  logic        dc_req,
   input  logic        dc_rw,
   input  logic [31:0] dc_addr,
   input  logic [31:0] dc_wdata,
   input  logic [1:0]  dc_mode,
   output logic        dc_gnt,
   output logic        dc_rvalid,
   output logic [31:0] dc_rdata,
   output logic        mem_req,
   output logic        mem_rw,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [1:0]  mem_mode,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        err
);

   localparam int SCW = $clog2(STARVE_MAX + 1);
   localparam int WCW = $clog2(TIMEOUT + 1);

   arb_state_t     state;
   logic [SCW-1:0] starve_cnt;
   logic [WCW-1:0] wait_cnt;
   logic           pick_if;
   logic           starved;

   // Fetch wins when it is alone or has waited out STARVE_MAX data grants.
   assign starved = (starve_cnt == SCW'(STARVE_MAX));
   assign pick_if = if_req && (!dc_req || starved);

   // Grants are combinational so a request is accepted in the cycle it is
   // seen in IDLE; rstn gating keeps them low while reset is asserted.
   assign if_gnt  = rstn && (state == ST_IDLE) && pick_if;
   assign dc_gnt  = rstn && (state == ST_IDLE) && dc_req && !pick_if;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= ST_IDLE;
         starve_cnt <= '0;
         wait_cnt   <= '0;
         mem_req    <= 1'b0;
         mem_rw     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_mode   <= '0;
         if_rvalid  <= 1'b0;
         if_rdata   <= '0;
         dc_rvalid  <= 1'b0;
         dc_rdata   <= '0;
         err        <= 1'b0;
      end else begin
         if_rvalid <= 1'b0;
         dc_rvalid <= 1'b0;
         err       <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (if_gnt) begin
                  state      <= ST_IF_BUSY;
                  mem_req    <= 1'b1;
                  mem_rw     <= 1'b0;
                  mem_addr   <= if_addr;
                  mem_wdata  <= '0;
                  mem_mode   <= MODE_WORD;
                  wait_cnt   <= '0;
                  starve_cnt <= '0;
               end else if (dc_gnt) begin
                  state     <= ST_DC_BUSY;
                  mem_req   <= 1'b1;
                  mem_rw    <= dc_rw;
                  mem_addr  <= dc_addr;
                  mem_wdata <= dc_wdata;
                  mem_mode  <= dc_mode;
                  wait_cnt  <= '0;
                  // Only grants that make fetch wait count toward starvation.
                  if (if_req && !starved) begin
                     starve_cnt <= starve_cnt + SCW'(1);
                  end
               end
            end
            ST_IF_BUSY, ST_DC_BUSY: begin
               // An ack in the same cycle as the timeout still completes.
               if (mem_ack) begin
                  state   <= ST_IDLE;
                  mem_req <= 1'b0;
                  if (state == ST_IF_BUSY) begin
                     if_rvalid <= 1'b1;
                     if_rdata  <= mem_rdata;
                  end else begin
                     dc_rvalid <= 1'b1;
                     dc_rdata  <= mem_rw ? '0 : mem_rdata;
                  end
               end else if (wait_cnt == WCW'(TIMEOUT)) begin
                  state   <= ST_IDLE;
                  mem_req <= 1'b0;
                  err     <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + WCW'(1);
               end
            end
            default: begin
               state   <= ST_IDLE;
               mem_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

   localparam int STARVE_MAX = 4;
   localparam int TIMEOUT    = 8;

   logic        clk;
   logic        rstn;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_gnt;
   logic        if_rvalid;
   logic [31:0] if_rdata;
   logic        dc_req;
   logic        dc_rw;
   logic [31:0] dc_addr;
   logic [31:0] dc_wdata;
   logic [1:0]  dc_mode;
   logic        dc_gnt;
   logic        dc_rvalid;
   logic [31:0] dc_rdata;
   logic        mem_req;
   logic        mem_rw;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [1:0]  mem_mode;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        err;

   int tests;
   int fails;
   int sc;          // consecutive data grants made while fetch was waiting

   mem_port_arbiter #(
      .STARVE_MAX(STARVE_MAX),
      .TIMEOUT   (TIMEOUT)
   ) dut (
      .clk      (clk),
      .rstn     (rstn),
      .if_req   (if_req),
      .if_addr  (if_addr),
      .if_gnt   (if_gnt),
      .if_rvalid(if_rvalid),
      .if_rdata (if_rdata),
      .dc_req   (dc_req),
      .dc_rw    (dc_rw),
      .dc_addr  (dc_addr),
      .dc_wdata (dc_wdata),
      .dc_mode  (dc_mode),
      .dc_gnt   (dc_gnt),
      .dc_rvalid(dc_rvalid),
      .dc_rdata (dc_rdata),
      .mem_req  (mem_req),
      .mem_rw   (mem_rw),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .mem_mode (mem_mode),
      .mem_ack  (mem_ack),
      .mem_rdata(mem_rdata),
      .err      (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One arbitration round starting just after a rising edge with the DUT
   // idle. Memory acks on the lat-th busy cycle (lat=0: never).
   task automatic run_txn(input bit ir, input bit dr, input int lat,
                          input logic [31:0] rd, output bit got_if);
      bit          gi;
      logic        e_rw;
      logic [31:0] e_addr;
      logic [31:0] e_wdata;
      logic [1:0]  e_mode;
      logic [31:0] e_rdata;
      if_req = ir;
      dc_req = dr;
      gi     = ir && (!dr || sc == STARVE_MAX);
      got_if = gi;
      if (gi) begin
         e_rw = 1'b0; e_addr = if_addr; e_wdata = 32'h0; e_mode = 2'b10;
      end else begin
         e_rw = dc_rw; e_addr = dc_addr; e_wdata = dc_wdata; e_mode = dc_mode;
      end
      e_rdata = (!gi && e_rw) ? 32'h0 : rd;
      @(negedge clk);
      chk("if_gnt", 32'(if_gnt), 32'(gi));
      chk("dc_gnt", 32'(dc_gnt), 32'(!gi));
      @(posedge clk); #1;
      if (gi) sc = 0;
      else if (ir && sc < STARVE_MAX) sc = sc + 1;
      if (gi) if_req = 1'b0; else dc_req = 1'b0;
      chk("mem_req_at_grant", 32'(mem_req), 32'd1);
      chk("mem_rw", 32'(mem_rw), 32'(e_rw));
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_mode", 32'(mem_mode), 32'(e_mode));
      if (!gi) chk("mem_wdata", mem_wdata, e_wdata);
      for (int c = 1; c <= TIMEOUT + 1; c++) begin
         mem_ack   = (c == lat);
         mem_rdata = mem_ack ? rd : $urandom;
         @(negedge clk);
         chk("busy_gnt", 32'({if_gnt, dc_gnt}), 32'd0);
         @(posedge clk); #1;
         mem_ack = 1'b0;
         if (c == lat) begin
            chk("if_rvalid", 32'(if_rvalid), 32'(gi));
            chk("dc_rvalid", 32'(dc_rvalid), 32'(!gi));
            if (gi) chk("if_rdata", if_rdata, e_rdata);
            else    chk("dc_rdata", dc_rdata, e_rdata);
            chk("err_on_ack", 32'(err), 32'd0);
            chk("mem_req_done", 32'(mem_req), 32'd0);
            break;
         end else if (c == TIMEOUT + 1) begin
            chk("err_timeout", 32'(err), 32'd1);
            chk("rvalid_on_timeout", 32'({if_rvalid, dc_rvalid}), 32'd0);
            chk("mem_req_timeout", 32'(mem_req), 32'd0);
         end else begin
            chk("mem_req_hold", 32'(mem_req), 32'd1);
            chk("mem_addr_hold", mem_addr, e_addr);
            chk("busy_quiet", 32'({if_rvalid, dc_rvalid, err}), 32'd0);
         end
      end
   endtask

   // One cycle with no requests; a stray mem_ack must be ignored.
   task automatic idle_cycle();
      if_req  = 1'b0;
      dc_req  = 1'b0;
      mem_ack = 1'b1;
      mem_rdata = $urandom;
      @(negedge clk);
      chk("idle_gnt", 32'({if_gnt, dc_gnt}), 32'd0);
      @(posedge clk); #1;
      mem_ack = 1'b0;
      chk("idle_quiet", 32'({mem_req, if_rvalid, dc_rvalid, err}), 32'd0);
   endtask

   initial begin
      bit    g;
      string order;
      tests = 0;
      fails = 0;
      sc    = 0;
      order = "DDDDIDDDDI";
      rstn = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h0;
      if_req = 1'b1; if_addr = 32'h40;
      dc_req = 1'b1; dc_rw = 1'b1; dc_addr = 32'h80; dc_wdata = 32'h1; dc_mode = 2'b10;

      // Reset state with both requests asserted
      #12;
      chk("rst_gnt", 32'({if_gnt, dc_gnt}), 32'd0);
      chk("rst_outs", 32'({mem_req, mem_rw, mem_mode, if_rvalid, dc_rvalid, err}), 32'd0);
      chk("rst_addr", mem_addr, 32'h0);
      chk("rst_rdata", if_rdata | dc_rdata, 32'h0);
      if_req = 1'b0; dc_req = 1'b0;
      @(posedge clk); #1;
      rstn = 1'b1;

      // Fetch at 0x100, ack on second busy cycle, first edge after reset
      if_addr = 32'h100;
      run_txn(1'b1, 1'b0, 2, 32'hDEADBEEF, g);

      // Byte write, single-cycle ack
      dc_rw = 1'b1; dc_addr = 32'h2000; dc_wdata = 32'h55; dc_mode = 2'b00;
      run_txn(1'b0, 1'b1, 1, 32'hCAFEF00D, g);
      idle_cycle();

      // Reset in the middle of a data read
      dc_rw = 1'b0; dc_addr = 32'h3000; dc_mode = 2'b01; dc_req = 1'b1;
      @(negedge clk);
      chk("mid_dc_gnt", 32'(dc_gnt), 32'd1);
      @(posedge clk); #1;
      dc_req = 1'b0;
      chk("mid_mem_req", 32'(mem_req), 32'd1);
      #2;
      rstn = 1'b0;
      #1;
      chk("mid_rst_outs", 32'({mem_req, mem_rw, mem_mode, dc_rvalid, err}), 32'd0);
      chk("mid_rst_addr", mem_addr, 32'h0);
      sc = 0;
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk); #1;
      mem_ack = 1'b1; mem_rdata = 32'h12345678;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      chk("post_rst_ack", 32'({dc_rvalid, if_rvalid, err, mem_req}), 32'd0);
      for (int i = 0; i < TIMEOUT + 3; i++) begin
         @(posedge clk); #1;
         chk("post_rst_quiet", 32'({dc_rvalid, if_rvalid, err, mem_req}), 32'd0);
      end

      // Both requesters held continuously: starvation rotation
      for (int i = 0; i < 10; i++) begin
         if (!if_req) if_addr = $urandom;
         if (!dc_req) begin
            dc_rw = 1'($urandom); dc_addr = $urandom;
            dc_wdata = $urandom; dc_mode = 2'($urandom_range(0, 2));
         end
         run_txn(1'b1, 1'b1, 1, $urandom, g);
         chk("grant_order", 32'(g), 32'(order[i] == "I"));
      end

      // Timeout: never acked, then the still-pending request is granted
      if_addr = $urandom;
      run_txn(1'b1, 1'b1, 0, 32'h0, g);
      run_txn(if_req, dc_req, 3, $urandom, g);
      // Ack in the very cycle the timeout would fire wins
      dc_rw = 1'b0; dc_addr = $urandom; dc_mode = 2'b10;
      if (!if_req) if_addr = $urandom;
      run_txn(if_req, 1'b1, TIMEOUT + 1, 32'hA5A5A5A5, g);

      // Randomized traffic
      for (int i = 0; i < 40; i++) begin
         bit ir, dr;
         ir = if_req | 1'($urandom);
         dr = dc_req | 1'($urandom);
         if (!if_req) if_addr = $urandom;
         if (!dc_req) begin
            dc_rw = 1'($urandom); dc_addr = $urandom;
            dc_wdata = $urandom; dc_mode = 2'($urandom_range(0, 2));
         end
         if (!ir && !dr) idle_cycle();
         else run_txn(ir, dr, $urandom_range(1, TIMEOUT + 2), $urandom, g);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4: max consecutive data grants while fetch waits.
REQ-002 Parameter TIMEOUT, default 255: max cycles waiting for mem_ack before abort.
REQ-003 Reset rstn SHALL be asynchronous, active-low; clock clk.
REQ-004 clk  in  1  clock.
REQ-005 rstn  in  1  async active-low reset.
REQ-006 if_req  in  1  fetch read request; if_addr  in  32  fetch address.
REQ-007 if_gnt  out  1  fetch request accepted (pulse).
REQ-008 if_rvalid  out  1  fetch data valid (pulse); if_rdata  out  32  fetch data.
REQ-009 dc_req  in  1  data request; dc_rw  in  1  1=write, 0=read.
REQ-010 dc_addr  in  32; dc_wdata  in  32; dc_mode  in  2  byte/half/word size.
REQ-011 dc_gnt  out  1  data request accepted (pulse).
REQ-012 dc_rvalid  out  1  data access complete (pulse, reads and writes); dc_rdata  out  32.
REQ-013 mem_req  out  1; mem_rw  out  1; mem_addr  out  32; mem_wdata  out  32; mem_mode  out  2.
REQ-014 mem_ack  in  1  memory completion; mem_rdata  in  32  valid when mem_ack=1.
REQ-015 err  out  1  timeout abort (pulse).

Function
REQ-016 FSM states IDLE, IF_BUSY, DC_BUSY.
REQ-017 IDLE, no request: stay IDLE; all gnt/mem_req low.
REQ-018 IDLE, only one request: grant it combinationally same cycle (x_gnt=1); next state that requester's BUSY.
REQ-019 IDLE, both requests: grant data unless starve_cnt==STARVE_MAX, then grant fetch.
REQ-020 At grant, latch addr/rw/wdata/mode into mem_* registers; fetch grant drives mem_rw=0, mem_mode=word (2'b10).
REQ-021 BUSY: mem_req held 1 with stable mem_* until mem_ack sampled 1.
REQ-022 BUSY & mem_ack: next cycle owner x_rvalid=1 for one cycle, x_rdata=registered mem_rdata; state -> IDLE; mem_req 0.
REQ-023 Minimum grant-to-grant spacing: grant, >=1 BUSY cycle, 1 IDLE cycle; no grant while BUSY.
REQ-024 Requester holds req and payload stable until gnt; arbiter ignores req while BUSY.
REQ-025 starve_cnt (width clog2(STARVE_MAX+1)): +1 on data grant with if_req=1, saturating at STARVE_MAX; cleared on fetch grant; unchanged otherwise.
REQ-026 wait_cnt: cleared at grant, +1 each BUSY cycle without mem_ack.
REQ-027 wait_cnt==TIMEOUT and no mem_ack: err pulse next cycle, mem_req 0, state -> IDLE, no rvalid issued.
REQ-028 mem_ack in IDLE ignored; mem_ack and timeout same cycle: ack wins, no err.
REQ-029 dc_rdata on write completion = 0.
REQ-030 At most one of if_gnt/dc_gnt per cycle; at most one of if_rvalid/dc_rvalid/err per cycle.

Reset
REQ-031 rstn low: state IDLE, starve_cnt 0, wait_cnt 0, all outputs 0, immediately (async).
REQ-032 Reset mid-transaction abandons it: no rvalid, no err after release.
REQ-033 First grant possible the first clk edge after rstn deasserts.

Structure
REQ-034 Shared package core_pkg holds arb_state_t enum and data-mode constants MODE_BYTE=2'b00, MODE_HALF=2'b01, MODE_WORD=2'b10.
REQ-035 Single module; no sub-module; FSM, counters and output registers in one file.

Verification
REQ-036 if_req only, addr 0x100, mem_ack 2 cycles after mem_req, rdata 0xDEADBEEF -> if_gnt cycle 0, if_rvalid with 0xDEADBEEF cycle 3.
REQ-037 dc write addr 0x2000, wdata 0x55, mode byte, ack 1 cycle -> mem_rw=1, mem_mode=00, dc_rvalid pulse, dc_rdata 0.
REQ-038 if_req and dc_req held continuously, ack 1 cycle -> grant order D,D,D,D,I,D,D,D,D,I (STARVE_MAX=4).
REQ-039 TIMEOUT=8, mem_ack never -> err pulse one cycle after the 8th wait cycle, state IDLE, next pending request granted.
REQ-040 rstn low while DC_BUSY, then ack arrives after release -> no dc_rvalid, outputs 0, FSM IDLE.
